updown_counter_mod: RTL and testbench
=====================================

// Module: updown_counter_mod
// PURPOSE
//  Parametrised synchronous up/down modulo-N counter; next generation of the 4-bit reversible counter.
//  Adds configurable width/modulus, parallel load, count enable, cascade carry-in/out,
//  wrap/saturate mode and a sticky overflow flag. Used stand-alone (timers, BCD digits) or chained
//  into multi-digit counters feeding display drivers.
// PARAMETERS
//  WIDTH      4    counter width in bits
//  MODULUS    16   count range 0..MODULUS-1; legal 2..2**WIDTH
//  RESET_VAL  0    value loaded by rst; must be < MODULUS
// PORTS
//  clk      in   1      clock, all state on rising edge
//  rst      in   1      synchronous reset, active-high
//  en       in   1      count enable (shared across a cascade)
//  ci       in   1      cascade carry-in; tie 1 on least-significant stage
//  up       in   1      direction: 1 = count up, 0 = count down
//  sat      in   1      mode: 0 = wrap, 1 = saturate at terminal
//  load     in   1      parallel load strobe
//  din      in   WIDTH  parallel load value
//  ovf_clr  in   1      clears sticky overflow flag
//  cnt      out  WIDTH  current count (registered)
//  tc       out  1      terminal count, combinational: (up & cnt==MODULUS-1) | (~up & cnt==0)
//  co       out  1      cascade carry-out, combinational: en & ci & tc; drives next stage ci
//  ovf      out  1      sticky overflow/underflow flag (registered)
// BEHAVIOUR
//  - Reset: cnt=RESET_VAL, ovf=0; tc/co follow from cnt/inputs immediately after.
//  - Per-edge priority: rst > load > step (en & ci) > hold.
//  - load: cnt <= din if din < MODULUS, else cnt <= MODULUS-1 (clamp). No ovf effect; step ignored.
//  - step, not at terminal: cnt <= cnt+1 (up) or cnt-1 (down); latency 1 cycle.
//  - step at terminal, sat=0: up MODULUS-1 -> 0, down 0 -> MODULUS-1; ovf <= 1.
//  - step at terminal, sat=1: cnt holds; ovf <= 1.
//  - ovf: set by terminal step as above; cleared by ovf_clr; set and clear same cycle -> set wins.
//  - en=0 or ci=0: cnt holds, ovf holds (ovf_clr still acts); load still acts.
//  - up/sat may change any cycle; take effect on the same edge; tc/co re-evaluate combinationally.
//  - cnt never leaves 0..MODULUS-1; no intermediate value above MODULUS-1 is ever registered.
//  - Arithmetic in WIDTH bits; terminal compare uses MODULUS-1 truncated to WIDTH (MODULUS=2**WIDTH
//    gives natural binary wrap).
//  - Elaboration check: MODULUS out of range or RESET_VAL >= MODULUS -> $error/stop in simulation.
// STRUCTURE
//  - Shared include counter_defs.vh: CNT_DIR_UP=1'b1, CNT_DIR_DOWN=1'b0, CNT_MODE_WRAP=1'b0,
//    CNT_MODE_SAT=1'b1; reused by later timer/prescaler blocks.
//  - One sub-module: cnt_next_step (combinational) computing {next_cnt, tc, wrap_evt} from
//    cnt, up, sat, MODULUS; top holds the cnt/ovf registers, load clamp and priority mux.
// TESTING  (WIDTH=4, MODULUS=10 unless stated)
//  1. rst, then en=ci=up=1, sat=0, 10 clocks -> cnt 0..9,0; tc=co=1 only while cnt=9; ovf=1 after wrap.
//  2. cnt=0, up=0, one step -> cnt=9, ovf=1; ovf_clr pulse -> ovf=0; clr with new wrap same cycle -> ovf=1.
//  3. sat=1, up=1 from 8: 3 steps -> 9,9,9, ovf=1; up=0 at 0 -> holds 0, ovf=1.
//  4. load din=6 with en=1 -> cnt=6 (no step); load din=12 -> cnt=9; load with en=0 -> still loads.
//  5. Two stages cascaded (co->ci, shared en), count from 98 up: 99 -> 00, upper co=1 at 99 only;
//     en=0 for one cycle at 09 -> both stages hold.
//  6. rst asserted with load=1, din=7, cnt=5 -> cnt=RESET_VAL(0), ovf=0; MODULUS=16 binary: 15 -> 0 wraps.

Source files
------------

// File: rtl/updown_counter_mod_pkg.sv
// Shared counter definitions for updown_counter_mod and the timer/prescaler
// blocks built on top of it. Direction and mode encodings live here so that
// every block decodes the up/sat control lines the same way.
package updown_counter_mod_pkg;

    localparam logic CNT_DIR_UP    = 1'b1;
    localparam logic CNT_DIR_DOWN  = 1'b0;
    localparam logic CNT_MODE_WRAP = 1'b0;
    localparam logic CNT_MODE_SAT  = 1'b1;

endpackage

// File: rtl/updown_counter_mod_cnt_next_step.sv
// cnt_next_step: combinational step logic for the modulo-N up/down counter.
// Given the current count, direction and mode it produces the value the
// counter would take if it stepped, the terminal-count flag and the
// overflow/underflow event (a step taken while at terminal).
// Ports:
//   cnt_i      current count
//   up_i       direction (1 = up, 0 = down)
//   sat_i      mode (0 = wrap, 1 = saturate)
//   step_i     a step is being taken this edge
//   nextCnt_o  stepped count value
//   tc_o       terminal count for the current direction
//   wrapEvt_o  step at terminal (overflow or underflow)
module cnt_next_step
    import updown_counter_mod_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             up_i,
    input  logic             sat_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] nextCnt_o,
    output logic             tc_o,
    output logic             wrapEvt_o
);

    // Truncating MODULUS-1 to WIDTH makes MODULUS = 2**WIDTH a plain binary counter.
    localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

    // Terminal detection and the stepped value. At terminal the counter either
    // wraps to the opposite end of the range or, when saturating, stays put,
    // so no value above TERM is ever produced.
    always_comb begin
        nextCnt_o = cnt_i;
        if (up_i == CNT_DIR_UP) begin
            tc_o = (cnt_i == TERM);
        end else begin
            tc_o = (cnt_i == '0);
        end
        if (tc_o) begin
            if (sat_i == CNT_MODE_WRAP) begin
                nextCnt_o = (up_i == CNT_DIR_UP) ? '0 : TERM;
            end
        end else if (up_i == CNT_DIR_UP) begin
            nextCnt_o = cnt_i + WIDTH'(1);
        end else begin
            nextCnt_o = cnt_i - WIDTH'(1);
        end
        wrapEvt_o = step_i & tc_o;
    end

endmodule

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised synchronous up/down modulo-N counter with
// parallel load, count enable, cascade carry-in/out, wrap/saturate mode and a
// sticky overflow flag. Stages chain by driving the next stage's ci_i from co_o
// while sharing en_i.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   en_i        count enable
//   ci_i        cascade carry-in (tie high on the least-significant stage)
//   up_i        direction, sat_i mode (wrap/saturate)
//   load_i      parallel load strobe, din_i load value (clamped to MODULUS-1)
//   ovf_clr_i   clears the sticky overflow flag
//   cnt_o       registered count, always within 0..MODULUS-1
//   tc_o        combinational terminal count for the current direction
//   co_o        combinational carry-out, en_i & ci_i & tc_o
//   ovf_o       sticky overflow/underflow flag
module updown_counter_mod
    import updown_counter_mod_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             ci_i,
    input  logic             up_i,
    input  logic             sat_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             ovf_clr_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o,
    output logic             co_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] TERM    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH) || RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : gBadParams
        $error("updown_counter_mod: illegal MODULUS=%0d / RESET_VAL=%0d for WIDTH=%0d",
               MODULUS, RESET_VAL, WIDTH);
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] nextCnt;
    logic             step;
    logic             tc;
    logic             wrapEvt;

    assign step = en_i & ci_i;

    cnt_next_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) uStep (
        .cnt_i     (cnt_q),
        .up_i      (up_i),
        .sat_i     (sat_i),
        .step_i    (step),
        .nextCnt_o (nextCnt),
        .tc_o      (tc),
        .wrapEvt_o (wrapEvt)
    );

    // Priority mux below reset: load beats step beats hold. The clear is applied
    // first so a terminal step in the same cycle re-sets the flag (set wins),
    // while a load suppresses the step and therefore any new overflow.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (load_i) begin
            cnt_d = (din_i > TERM) ? TERM : din_i;
        end else if (step) begin
            cnt_d = nextCnt;
            if (wrapEvt) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Count and overflow registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_CNT;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
    assign tc_o  = tc;
    assign co_o  = step & tc;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Testbench for updown_counter_mod. Four instances share stimulus: a stand-alone
// modulo-10 counter, a two-digit modulo-10 cascade (lo.co_o -> hi.ci_i) and a
// modulo-16 binary counter. Each stimulus cycle updates a behavioural model and
// pushes the expected post-edge outputs into a queue; a monitor pops and checks.
module tb_updown_counter_mod;

    typedef struct packed {
        logic [3:0][3:0] cnt;
        logic [3:0]      ovf;
        logic [3:0]      tc;
        logic [3:0]      co;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0, ciA = 1'b0, up = 1'b0, sat = 1'b0, load = 1'b0, ovfClr = 1'b0;
    logic [3:0] dinA = '0, dinLo = '0, dinHi = '0;

    logic [3:0] cntA, cntLo, cntHi, cntC;
    logic tcA, tcLo, tcHi, tcC, coA, coLo, coHi, coC, ovfA, ovfLo, ovfHi, ovfC;

    expT sbQ[$];
    int vecCount = 0;
    int failCount = 0;

    int mv[4];
    bit mo[4];
    int modulus[4] = '{10, 10, 10, 16};

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) uA (
        .clk(clk), .rst(rst), .en_i(en), .ci_i(ciA), .up_i(up), .sat_i(sat),
        .load_i(load), .din_i(dinA), .ovf_clr_i(ovfClr),
        .cnt_o(cntA), .tc_o(tcA), .co_o(coA), .ovf_o(ovfA));

    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) uLo (
        .clk(clk), .rst(rst), .en_i(en), .ci_i(1'b1), .up_i(up), .sat_i(sat),
        .load_i(load), .din_i(dinLo), .ovf_clr_i(ovfClr),
        .cnt_o(cntLo), .tc_o(tcLo), .co_o(coLo), .ovf_o(ovfLo));

    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) uHi (
        .clk(clk), .rst(rst), .en_i(en), .ci_i(coLo), .up_i(up), .sat_i(sat),
        .load_i(load), .din_i(dinHi), .ovf_clr_i(ovfClr),
        .cnt_o(cntHi), .tc_o(tcHi), .co_o(coHi), .ovf_o(ovfHi));

    updown_counter_mod #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) uC (
        .clk(clk), .rst(rst), .en_i(en), .ci_i(ciA), .up_i(up), .sat_i(sat),
        .load_i(load), .din_i(dinA), .ovf_clr_i(ovfClr),
        .cnt_o(cntC), .tc_o(tcC), .co_o(coC), .ovf_o(ovfC));

    // Reference behaviour of one counter for one clock edge, written in terms of
    // integer values: reset, clamped load, otherwise an optional step that
    // wraps or saturates at the end of the range and flags overflow.
    function automatic void modelEdge(input int idx, input int dinV, input bit stepV,
                                      input bit r, input bit ld, input bit u,
                                      input bit s, input bit clr);
        int m;
        bit atTerm;
        m = modulus[idx];
        atTerm = u ? (mv[idx] == m - 1) : (mv[idx] == 0);
        if (r) begin
            mv[idx] = 0;
            mo[idx] = 1'b0;
        end else begin
            if (clr) mo[idx] = 1'b0;
            if (ld) begin
                mv[idx] = (dinV >= m) ? m - 1 : dinV;
            end else if (stepV) begin
                if (atTerm) begin
                    mo[idx] = 1'b1;
                    if (!s) mv[idx] = u ? 0 : m - 1;
                end else begin
                    mv[idx] = u ? mv[idx] + 1 : mv[idx] - 1;
                end
            end
        end
    endfunction

    // Drive one cycle of stimulus on the falling edge, advance the model and
    // queue what every instance should show just after the next rising edge.
    task automatic applyStimulus(input bit r, input bit ld, input int dA, input int dLo,
                                 input int dHi, input bit e, input bit c, input bit u,
                                 input bit s, input bit clr);
        expT x;
        bit loTermBefore;
        @(negedge clk);
        rst = r; load = ld; en = e; ciA = c; up = u; sat = s; ovfClr = clr;
        dinA = 4'(dA); dinLo = 4'(dLo); dinHi = 4'(dHi);
        loTermBefore = u ? (mv[1] == 9) : (mv[1] == 0);
        modelEdge(0, dA, e & c, r, ld, u, s, clr);
        modelEdge(1, dLo, e, r, ld, u, s, clr);
        modelEdge(2, dHi, e & loTermBefore, r, ld, u, s, clr);
        modelEdge(3, dA, e & c, r, ld, u, s, clr);
        for (int i = 0; i < 4; i++) begin
            x.cnt[i] = 4'(mv[i]);
            x.ovf[i] = mo[i];
            x.tc[i]  = u ? (mv[i] == modulus[i] - 1) : (mv[i] == 0);
        end
        x.co[0] = e & c & x.tc[0];
        x.co[1] = e & x.tc[1];
        x.co[2] = e & x.tc[1] & x.tc[2];
        x.co[3] = e & c & x.tc[3];
        sbQ.push_back(x);
        @(posedge clk);
    endtask

    task automatic checkOutput(input string nm, input int idx, input int act, input int exp);
        vecCount++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s[%0d] at %0t: actual=%0d required=%0d", nm, idx, $time, act, exp);
        end
    endtask

    // Monitor: just after each rising edge, compare the DUTs against the oldest
    // queued expectation.
    initial begin : monitor
        expT e;
        logic [3:0][3:0] actCnt;
        logic [3:0] actOvf, actTc, actCo;
        forever begin
            @(posedge clk);
            #1;
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                actCnt = {cntC, cntHi, cntLo, cntA};
                actOvf = {ovfC, ovfHi, ovfLo, ovfA};
                actTc  = {tcC, tcHi, tcLo, tcA};
                actCo  = {coC, coHi, coLo, coA};
                for (int i = 0; i < 4; i++) begin
                    checkOutput("cnt", i, int'(actCnt[i]), int'(e.cnt[i]));
                    checkOutput("ovf", i, int'(actOvf[i]), int'(e.ovf[i]));
                    checkOutput("tc",  i, int'(actTc[i]),  int'(e.tc[i]));
                    checkOutput("co",  i, int'(actCo[i]),  int'(e.co[i]));
                end
            end
        end
    end

    // Directed scenarios first, then randomized traffic.
    initial begin : stimulus
        // args: rst load dinA dinLo dinHi en ci up sat clr
        // 1. reset, count up through a full wrap.
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        // 2. underflow wrap, clear, then clear colliding with a new wrap.
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        // 3. saturate up from 8, then saturate down at 0.
        applyStimulus(0, 1, 8, 8, 8, 0, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        // 4. load overrides step, clamps above range, works with en low.
        applyStimulus(0, 1, 6, 6, 6, 1, 1, 1, 0, 0);
        applyStimulus(0, 1, 12, 12, 12, 1, 1, 1, 0, 0);
        applyStimulus(0, 1, 3, 3, 3, 0, 1, 1, 0, 0);
        // 5. cascade 98 -> 99 -> 00, then 08 -> 09, hold, -> 10.
        applyStimulus(0, 1, 0, 8, 9, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 8, 0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        // 6. reset beats load; binary wrap 15 -> 0 on the modulo-16 instance.
        applyStimulus(0, 1, 5, 5, 5, 0, 1, 1, 0, 0);
        applyStimulus(1, 1, 7, 7, 7, 1, 1, 1, 0, 0);
        applyStimulus(0, 1, 15, 15, 15, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        // ci low blocks stepping on the single-stage instances.
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)),
                          $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 9) == 0);
        end
        for (int k = 0; k < 10 && sbQ.size() != 0; k++) @(posedge clk);
        #3;
        if (sbQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", sbQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
